// File: rtl/assoc_cache_controller.sv
// N-way set-associative write-back / write-allocate cache controller.
// Ports: clk, reset; cpu_* load/store side; mem_* ready/valid memory side.
module assoc_cache_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_in,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_data_out,
  output logic              cpu_ready,
  output logic              cache_hit,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   dirty_q  [SETS];
  logic [WAY_W-1:0]  rr_q     [SETS];

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_wr;
  logic [WAY_W-1:0]  vict_q;
  logic [DATA_W-1:0] rd_q;
  logic              hit_q;

  logic              req_any;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_any;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  vict_sel;
  logic              vict_dirty;

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0] t,
    input logic [IDX_W-1:0] i
  );
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1 -: TAG_W] = t;
    a[OFF_W +: IDX_W] = i;
    return a;
  endfunction

  assign req_any = cpu_read | cpu_write;

  // In IDLE the lookup uses the live request; afterwards the latched one.
  assign idx = (state == S_IDLE) ? cpu_address[OFF_W +: IDX_W]
                                 : req_addr[OFF_W +: IDX_W];
  assign tag = (state == S_IDLE) ? cpu_address[ADDR_W-1 -: TAG_W]
                                 : req_addr[ADDR_W-1 -: TAG_W];

  // Scanning downward leaves the lowest-index invalid way selected.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign vict_sel   = inv_any ? inv_way : rr_q[idx];
  assign vict_dirty = valid_q[idx][vict_sel] & dirty_q[idx][vict_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_data_out = '0;
    cpu_ready    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_any) begin
          if (hit_any)         state_nx = S_DONE;
          else if (vict_dirty) state_nx = S_WB;
          else                 state_nx = S_FILL;
        end
      end
      S_WB: begin
        mem_write    = 1'b1;
        mem_address  = line_addr(tag_mem[idx][vict_q], idx);
        mem_data_out = data_mem[idx][vict_q];
        if (mem_ready) state_nx = S_FILL;
      end
      S_FILL: begin
        mem_read    = 1'b1;
        mem_address = req_addr & LINE_MASK;
        if (mem_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      req_addr <= '0;
      req_data <= '0;
      req_wr   <= 1'b0;
      vict_q   <= '0;
      rd_q     <= '0;
      hit_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_any) begin
            req_addr <= cpu_address;
            req_data <= cpu_data_in;
            req_wr   <= cpu_write;
            hit_q    <= hit_any;
            if (hit_any) begin
              if (cpu_write) begin
                data_mem[idx][hit_way] <= cpu_data_in;
                dirty_q[idx][hit_way]  <= 1'b1;
              end else begin
                rd_q <= data_mem[idx][hit_way];
              end
            end else begin
              vict_q <= vict_sel;
              // Pointer only moves past a way that held a valid line.
              if (!inv_any) begin
                rr_q[idx] <= (WAYS > 1) ? rr_q[idx] + 1'b1 : '0;
              end
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            tag_mem[idx][vict_q] <= tag;
            valid_q[idx][vict_q] <= 1'b1;
            dirty_q[idx][vict_q] <= req_wr;
            if (req_wr) begin
              data_mem[idx][vict_q] <= req_data;
            end else begin
              data_mem[idx][vict_q] <= mem_data_in;
              rd_q <= mem_data_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_data_out = rd_q;
  assign cache_hit    = hit_q;

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Bench for assoc_cache_controller: directed vector table, reset corner
// case, and random traffic against a flat-memory reference model.
module tb_assoc_cache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_address;
  logic [31:0] cpu_data_in;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_data_out;
  logic        cpu_ready;
  logic        cache_hit;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;

  assoc_cache_controller #(
    .ADDR_W(32), .DATA_W(32), .SETS(4), .WAYS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .cache_hit(cache_hit),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] mem  [int unsigned];
  logic [31:0] gold [int unsigned];
  bit noise = 0;

  bit          r_hit;
  logic [31:0] r_rdata;
  int          r_cyc;
  int          r_nrd;
  int          r_nwr;
  logic [31:0] r_rd_addr;
  logic [31:0] r_wb_addr;
  logic [31:0] r_wb_data;
  bit          r_wr_after_rd;

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return hsh(a);
  endfunction

  function automatic logic [31:0] gold_get(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return hsh(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    cpu_read = 0; cpu_write = 0; mem_ready = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // One CPU transaction, with the memory side played cycle by cycle.
  task automatic xact(input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int stall);
    logic [1:0]  prev_t, cur_t;
    logic [31:0] h_addr, h_data;
    int cnt;
    bit acked, done, seen_rd;
    cpu_write = wr; cpu_read = !wr;
    cpu_address = a; cpu_data_in = d;
    r_nrd = 0; r_nwr = 0; r_cyc = 0; r_wr_after_rd = 0;
    r_rd_addr = 0; r_wb_addr = 0; r_wb_data = 0;
    prev_t = 0; cnt = 0; acked = 0; done = 0; seen_rd = 0;
    h_addr = 0; h_data = 0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      chk("mem_excl", 32'(mem_read & mem_write), 0);
      chk("ready_vs_mem", 32'(cpu_ready & (mem_read | mem_write)), 0);
      mem_data_in = $urandom;
      cur_t = {mem_read, mem_write};
      if (cur_t != 0) begin
        if (cur_t != prev_t || acked) begin
          cnt = 0; h_addr = mem_address; h_data = mem_data_out;
        end else begin
          chk("mem_addr_stable", mem_address, h_addr);
          if (mem_write) chk("mem_wdata_stable", mem_data_out, h_data);
        end
        cnt++;
        acked = 0;
        if (cnt > stall) begin
          mem_ready = 1; acked = 1;
          if (mem_read) begin
            mem_data_in = mem_get(mem_address);
            r_nrd++; r_rd_addr = mem_address; seen_rd = 1;
          end else begin
            mem[mem_address] = mem_data_out;
            r_nwr++; r_wb_addr = mem_address; r_wb_data = mem_data_out;
            if (seen_rd) r_wr_after_rd = 1;
          end
        end else begin
          mem_ready = 0;
        end
      end else begin
        mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        acked = 0;
      end
      prev_t = cur_t;
      if (cpu_ready) begin
        r_hit = cache_hit; r_rdata = cpu_data_out; r_cyc = c;
        done = 1;
        cpu_read = 0; cpu_write = 0; mem_ready = 0;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: no cpu_ready for addr %h", a);
      cpu_read = 0; cpu_write = 0; mem_ready = 0;
    end
    @(negedge clk);
    chk("ready_pulse", 32'(cpu_ready), 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    bit          hit;
    logic [31:0] rdata;
    int          nrd;
    logic [31:0] rd_addr;
    int          nwr;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    int          cyc;
  } vec_t;

  function automatic vec_t mk(
    bit wr, logic [31:0] addr, logic [31:0] data, int stall, bit hit,
    logic [31:0] rdata, int nrd, logic [31:0] rd_addr, int nwr,
    logic [31:0] wb_addr, logic [31:0] wb_data, int cyc);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.stall = stall;
    v.hit = hit; v.rdata = rdata; v.nrd = nrd; v.rd_addr = rd_addr;
    v.nwr = nwr; v.wb_addr = wb_addr; v.wb_data = wb_data; v.cyc = cyc;
    return v;
  endfunction

  typedef struct {
    bit          v;
    bit          d;
    logic [31:0] tag;
    logic [31:0] data;
  } line_t;

  line_t       mdl [4][2];
  int          mrr [4];
  logic [31:0] m_out;

  task automatic mdl_clear();
    for (int s = 0; s < 4; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        mdl[s][w].v = 0; mdl[s][w].d = 0;
      end
    end
    m_out = 0;
  endtask

  vec_t vt[$];

  initial begin
    reset = 1; cpu_address = 0; cpu_data_in = 0;
    cpu_read = 0; cpu_write = 0; mem_data_in = 0; mem_ready = 0;
    do_reset();
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_cache_hit", 32'(cache_hit), 0);
    chk("rst_cpu_data_out", cpu_data_out, 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_out", mem_data_out, 0);

    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h24] = 32'h0;
    vt.push_back(mk(0, 32'h10, 0, 0, 0, 32'hDEADBEEF, 1, 32'h10, 0, 0, 0, 2));
    vt.push_back(mk(0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 32'h10, 32'h12345678, 0, 1, 32'hDEADBEEF,
                    0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h10, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h50, 0, 0, 0, hsh(32'h50), 1, 32'h50, 0, 0, 0, 2));
    vt.push_back(mk(0, 32'h90, 0, 0, 0, hsh(32'h90), 1, 32'h90,
                    1, 32'h10, 32'h12345678, 3));
    vt.push_back(mk(0, 32'h50, 0, 0, 1, hsh(32'h50), 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h10, 0, 0, 0, 32'h12345678, 1, 32'h10, 0, 0, 0, 2));
    vt.push_back(mk(0, 32'h14, 0, 5, 0, hsh(32'h14), 1, 32'h14, 0, 0, 0, 7));
    vt.push_back(mk(1, 32'h24, 32'hA5A5A5A5, 0, 0, hsh(32'h14),
                    1, 32'h24, 0, 0, 0, 2));
    vt.push_back(mk(0, 32'h34, 0, 0, 0, hsh(32'h34), 1, 32'h34, 0, 0, 0, 2));
    vt.push_back(mk(0, 32'h44, 0, 0, 0, hsh(32'h44), 1, 32'h44,
                    1, 32'h24, 32'hA5A5A5A5, 3));
    vt.push_back(mk(0, 32'h34, 0, 0, 1, hsh(32'h34), 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 32'h24, 0, 0, 0, 32'hA5A5A5A5, 1, 32'h24, 0, 0, 0, 2));

    foreach (vt[i]) begin
      xact(vt[i].wr, vt[i].addr, vt[i].data, vt[i].stall);
      chk($sformatf("v%0d_hit", i), 32'(r_hit), 32'(vt[i].hit));
      chk($sformatf("v%0d_rdata", i), r_rdata, vt[i].rdata);
      chk($sformatf("v%0d_nrd", i), r_nrd, vt[i].nrd);
      chk($sformatf("v%0d_nwr", i), r_nwr, vt[i].nwr);
      chk($sformatf("v%0d_cyc", i), r_cyc, vt[i].cyc);
      chk($sformatf("v%0d_order", i), 32'(r_wr_after_rd), 0);
      if (vt[i].nrd > 0)
        chk($sformatf("v%0d_rd_addr", i), r_rd_addr, vt[i].rd_addr);
      if (vt[i].nwr > 0) begin
        chk($sformatf("v%0d_wb_addr", i), r_wb_addr, vt[i].wb_addr);
        chk($sformatf("v%0d_wb_data", i), r_wb_data, vt[i].wb_data);
      end
    end

    // Reset while a fill is outstanding.
    cpu_address = 32'h200; cpu_read = 1; mem_ready = 0;
    @(negedge clk);
    chk("rf_mem_read_a", 32'(mem_read), 1);
    @(negedge clk);
    chk("rf_mem_read_b", 32'(mem_read), 1);
    reset = 1; cpu_read = 0;
    @(negedge clk);
    chk("rf_mem_read", 32'(mem_read), 0);
    chk("rf_mem_write", 32'(mem_write), 0);
    chk("rf_mem_address", mem_address, 0);
    chk("rf_mem_data_out", mem_data_out, 0);
    chk("rf_cpu_ready", 32'(cpu_ready), 0);
    chk("rf_cache_hit", 32'(cache_hit), 0);
    chk("rf_cpu_data_out", cpu_data_out, 0);
    reset = 0;
    @(negedge clk);
    xact(0, 32'h10, 0, 0);
    chk("rf_after_hit", 32'(r_hit), 0);
    chk("rf_after_rdata", r_rdata, 32'h12345678);

    // Random traffic: flat golden memory plus a per-set occupancy model.
    do_reset();
    gold = mem;
    mdl_clear();
    noise = 1;
    for (int n = 0; n < 400; n++) begin
      bit          wr, hit, wb;
      logic [31:0] a, al, d, tg, wba, wbd;
      int          st, ix, vw, ecyc;
      wr = 1'($urandom_range(0, 1));
      al = 32'($urandom_range(0, 31)) << 2;
      a  = al | 32'($urandom_range(0, 3));
      d  = $urandom;
      st = $urandom_range(0, 3);
      ix = int'(al[3:2]);
      tg = al >> 4;
      hit = 0; vw = 0; wb = 0; wba = 0; wbd = 0;
      for (int w = 0; w < 2; w++)
        if (mdl[ix][w].v && mdl[ix][w].tag == tg) begin
          hit = 1; vw = w;
        end
      if (!hit) begin
        if (!mdl[ix][0].v) vw = 0;
        else if (!mdl[ix][1].v) vw = 1;
        else begin
          vw = mrr[ix];
          mrr[ix] = (mrr[ix] + 1) % 2;
        end
        wb  = mdl[ix][vw].v && mdl[ix][vw].d;
        wba = (mdl[ix][vw].tag << 4) | 32'(ix << 2);
        wbd = mdl[ix][vw].data;
        mdl[ix][vw].v = 1;
        mdl[ix][vw].tag = tg;
        mdl[ix][vw].d = 0;
        mdl[ix][vw].data = gold_get(al);
      end
      if (wr) begin
        mdl[ix][vw].data = d;
        mdl[ix][vw].d = 1;
      end else begin
        m_out = gold_get(al);
      end
      ecyc = hit ? 1 : ((wb ? st + 1 : 0) + st + 2);
      xact(wr, a, d, st);
      chk("rnd_hit", 32'(r_hit), 32'(hit));
      chk("rnd_out", r_rdata, m_out);
      chk("rnd_cyc", r_cyc, ecyc);
      chk("rnd_nwr", r_nwr, 32'(wb));
      chk("rnd_nrd", r_nrd, 32'(!hit));
      if (!hit) chk("rnd_rd_addr", r_rd_addr, al);
      if (wb) begin
        chk("rnd_wb_addr", r_wb_addr, wba);
        chk("rnd_wb_data", r_wb_data, wbd);
      end
      if (wr) gold[al] = d;
    end
    noise = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assoc_cache_controller.md
# assoc_cache_controller

Parametrised N-way set-associative, write-back, write-allocate cache controller sitting between the CPU load/store port and main memory. It generalises the direct cache controller in four ways: configurable data and address width, set count and associativity; a ready/valid handshake on both sides instead of fixed timing; dirty-line write-back; and per-set round-robin replacement. One data word per line.

## Interface
- ADDR_W, 32: CPU/memory byte-address width.
- DATA_W, 32: word width; must be a power of two, at least 8.
- SETS, 4: number of sets; power of two, at least 2.
- WAYS, 2: associativity; power of two, at least 1.
- Derived: OFF_W = log2(DATA_W/8); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- cpu_address, input, ADDR_W: request byte address. Offset bits are ignored.
- cpu_data_in, input, DATA_W: store data.
- cpu_read, input, 1: load request; held until cpu_ready.
- cpu_write, input, 1: store request; held until cpu_ready. Takes priority if asserted together with cpu_read.
- cpu_data_out, output, DATA_W: load data; valid while cpu_ready=1.
- cpu_ready, output, 1: one-cycle completion pulse.
- cache_hit, output, 1: qualifies cpu_ready; 1 = hit, 0 = miss.
- mem_address, output, ADDR_W: word-aligned memory address.
- mem_data_out, output, DATA_W: write-back data to memory.
- mem_data_in, input, DATA_W: fill data from memory; sampled when mem_ready=1 during a read.
- mem_read, output, 1: level request; held until mem_ready.
- mem_write, output, 1: level request; held until mem_ready.
- mem_ready, input, 1: memory completion for the current request.

## Operation
- Address fields: index = addr[OFF_W +: IDX_W]; tag = addr[ADDR_W-1 -: TAG_W].
- Per way and per set: valid bit, dirty bit, tag, data. Per set: log2(WAYS)-bit round-robin pointer (rr).
- **IDLE**
  - Accepts a request when cpu_read or cpu_write is asserted, and latches address, data and operation.
  - Tag compare runs against all ways of the set.
  - On a hit:
    - A read loads cpu_data_out from the line.
    - A write updates the line data and sets dirty.
    - Sets cache_hit=1; next state DONE.
- **Miss victim selection:** the lowest-index invalid way; otherwise way rr[set]. rr increments (mod WAYS) only when a valid line is evicted.
- **Miss path:** if the victim is valid and dirty, go to WB; otherwise go to FILL. cache_hit is 0.
- **WB**
  - Drives mem_write=1, mem_address={victim tag, index, OFF_W'b0}, mem_data_out=victim data.
  - On mem_ready, moves to FILL.
- **FILL**
  - Drives mem_read=1, mem_address=request address with offset zeroed.
  - On mem_ready, installs tag and data (valid=1).
  - A write request merges cpu_data_in over the fill data and sets dirty=1. A read request sets dirty=0 and loads cpu_data_out with mem_data_in.
  - Next state DONE.
- **DONE:** cpu_ready=1 for exactly one cycle; requests are ignored; next state IDLE.
- mem_read and mem_write are never asserted together. Both are 0 in IDLE and DONE.
- For a write, cpu_data_out holds its previous value.

## Timing
- Reset (synchronous) clears:
  - all outputs to 0;
  - all valid and dirty bits;
  - all rr pointers;
  - state to IDLE.
- Tag and data arrays need no reset.
- Reset mid-operation: abandons any transaction. mem_read and mem_write are 0 from the cycle after the reset edge. Dirty data is discarded.
- Hit: request sampled at edge k; cpu_ready=1 during cycle k+1. Next request is accepted at edge k+2, so throughput is one hit per 2 cycles.
- Clean miss: mem_read rises in the cycle after the request edge. cpu_ready comes 1 cycle after the mem_ready edge.
- Dirty miss: WB phase first. mem_read rises in the cycle after the mem_write/mem_ready edge.
- mem_address, mem_data_out and request levels stay stable until mem_ready. mem_ready asserted while no request is active is ignored.
- The CPU must drop or change its request in the cycle cpu_ready=1. The held request is not re-sampled, because of DONE.

## Test plan
Configuration for all scenarios: SETS=4, WAYS=2, DATA_W=32, ADDR_W=32. Index is addr[3:2].
- **Read miss then hit:** after reset, read 0x10 with memory returning 0xDEADBEEF.
  - First read: one mem_read at address 0x10; cpu_data_out=0xDEADBEEF, cache_hit=0.
  - Repeat read: cache_hit=1, cpu_ready 1 cycle after the request, no memory traffic.
- **Write hit:** write 0x12345678 to 0x10 (resident). Required: cache_hit=1, no mem_write; a following read of 0x10 returns 0x12345678.
- **Dirty eviction with round-robin:** after the write above, read 0x50, then read 0x90.
  - 0x50 fills way1 with no mem_write.
  - 0x90: mem_write to address 0x10 with data 0x12345678 first, then mem_read at 0x90.
  - A subsequent read of 0x50 hits.
- **Memory stall:** mem_ready held low for 5 cycles during FILL. Required: mem_read stays 1, mem_address stays constant, cpu_ready stays 0; completion occurs 1 cycle after mem_ready.
- **Write-allocate miss:** write 0xA5A5A5A5 to 0x24 with a clean victim, memory returning 0. Required: no mem_write; one mem_read at 0x24; the line becomes dirty, and its later eviction writes 0xA5A5A5A5 to 0x24.
- **Reset during FILL:** assert reset while mem_read=1. Required: mem_read=0 the next cycle, all outputs 0; a following read of 0x10 misses.
